strip_id_sequencer: RTL

Parametrised successor to the fixed strip-ID lookup. It holds a run-time writable table of prioritised strip IDs indexed by a preprocessed height address. On request, it streams the valid IDs of the addressed entry one at a time, highest priority first, over a valid/ready handshake. It sits between the height-quantisation stage and the strip-selection logic, and any slot holding the all-ones ID is treated as unused.

---
 rtl/strip_id_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/strip_id_sequencer.sv
// rtl/strip_id_sequencer.sv - prioritised strip-ID table streaming one ID per beat over valid/ready
module strip_id_sequencer #(
    parameter  int ID_W    = 4,
    parameter  int NUM_PRI = 3,
    parameter  int DEPTH   = 10,
    parameter  int ADDR_W  = 4,
    localparam int ENTRY_W = NUM_PRI * ID_W,
    localparam int RANK_W  = (NUM_PRI > 1) ? $clog2(NUM_PRI) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ADDR_W-1:0]  req_addr,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [ID_W-1:0]    id,
    output logic [RANK_W-1:0]  id_rank,
    output logic               id_last,
    output logic               id_none
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_EMIT   = 2'd2
    } state_t;

    localparam logic [ID_W-1:0] UNUSED_ID = '1;

    state_t               state_q;
    logic [ENTRY_W-1:0]   tbl_q [DEPTH];
    logic [ADDR_W-1:0]    addr_q;
    logic [ENTRY_W-1:0]   snap_q;
    logic [NUM_PRI-1:0]   rem_q;
    logic                 id_valid_q;
    logic [ID_W-1:0]      id_q;
    logic [RANK_W-1:0]    id_rank_q;
    logic                 id_last_q;
    logic                 id_none_q;

    logic [ADDR_W-1:0]    req_addr_c;
    logic                 wr_in_range;
    logic [ENTRY_W-1:0]   lk_entry;
    logic [NUM_PRI-1:0]   lk_mask;
    logic [RANK_W-1:0]    lk_rank;
    logic [NUM_PRI-1:0]   lk_rem;
    logic [RANK_W-1:0]    nx_rank;
    logic [NUM_PRI-1:0]   nx_rem;

    // Bit i set when slot i of the entry holds a real ID (not all ones).
    function automatic logic [NUM_PRI-1:0] valid_mask(input logic [ENTRY_W-1:0] e);
        logic [NUM_PRI-1:0] m;
        for (int i = 0; i < NUM_PRI; i++) begin
            m[i] = (e[(NUM_PRI-1-i)*ID_W +: ID_W] != UNUSED_ID);
        end
        return m;
    endfunction

    // Lowest set index, i.e. the most important remaining slot.
    function automatic logic [RANK_W-1:0] first_set(input logic [NUM_PRI-1:0] m);
        logic [RANK_W-1:0] r;
        r = '0;
        for (int i = NUM_PRI-1; i >= 0; i--) begin
            if (m[i]) r = RANK_W'(i);
        end
        return r;
    endfunction

    // Slot 0 lives in the most-significant ID_W bits.
    function automatic logic [ID_W-1:0] slot_of(input logic [ENTRY_W-1:0] e,
                                                 input logic [RANK_W-1:0]  r);
        return e[(NUM_PRI-1-int'(r))*ID_W +: ID_W];
    endfunction

    assign req_addr_c  = ({1'b0, req_addr} >= (ADDR_W+1)'(DEPTH)) ? ADDR_W'(DEPTH-1) : req_addr;
    assign wr_in_range = ({1'b0, wr_addr} < (ADDR_W+1)'(DEPTH));

    // Slot selection for the first beat (from the table) and for following beats (from the snapshot mask).
    always_comb begin
        lk_entry = tbl_q[addr_q];
        lk_mask  = valid_mask(lk_entry);
        lk_rank  = first_set(lk_mask);
        lk_rem   = lk_mask & ~(NUM_PRI'(1) << lk_rank);
        nx_rank  = first_set(rem_q);
        nx_rem   = rem_q & ~(NUM_PRI'(1) << nx_rank);
    end

    // Table writes plus the IDLE/LOOKUP/EMIT sequencer with registered beat outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            snap_q     <= '1;
            rem_q      <= '0;
            id_valid_q <= 1'b0;
            id_q       <= '0;
            id_rank_q  <= '0;
            id_last_q  <= 1'b0;
            id_none_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= '1;
            end
        end else begin
            if (wr_en && wr_in_range) begin
                tbl_q[wr_addr] <= wr_data;
            end
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr_c;
                        state_q <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    // Table read here sees the pre-write value of a same-cycle write.
                    snap_q     <= lk_entry;
                    id_valid_q <= 1'b1;
                    state_q    <= S_EMIT;
                    if (lk_mask == '0) begin
                        id_q      <= UNUSED_ID;
                        id_rank_q <= '0;
                        id_none_q <= 1'b1;
                        id_last_q <= 1'b1;
                        rem_q     <= '0;
                    end else begin
                        id_q      <= slot_of(lk_entry, lk_rank);
                        id_rank_q <= lk_rank;
                        id_none_q <= 1'b0;
                        id_last_q <= (lk_rem == '0);
                        rem_q     <= lk_rem;
                    end
                end
                S_EMIT: begin
                    if (id_ready) begin
                        if (id_last_q) begin
                            id_valid_q <= 1'b0;
                            state_q    <= S_IDLE;
                        end else begin
                            id_q      <= slot_of(snap_q, nx_rank);
                            id_rank_q <= nx_rank;
                            id_none_q <= 1'b0;
                            id_last_q <= (nx_rem == '0);
                            rem_q     <= nx_rem;
                        end
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    id_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = (state_q == S_IDLE) && !rst;
    assign id_valid  = id_valid_q;
    assign id        = id_q;
    assign id_rank   = id_rank_q;
    assign id_last   = id_last_q;
    assign id_none   = id_none_q;

endmodule
